// File: rtl/mem_pkg.sv
// mem_pkg
//   Shared types and constants for the param_memory slice.
//   - state_t      : two-state access FSM (IDLE accepts, BUSY waits)
//   - MEM_READ/MEM_WRITE : encodings of the memory_rw request bit
//   - WAIT_CNT_W   : width of the wait-state down-counter (WAIT_STATES <= 7)
package mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

  localparam int WAIT_CNT_W = 3;

endpackage

// File: rtl/mem_array.sv
// mem_array
//   DEPTH x DATA_W storage with a synchronous per-byte-lane write port and a
//   synchronous read port. Contents are never reset.
//   Ports:
//     clk      - clock, rising edge
//     wr_en    - commit wr_data into word addr (lanes selected by be)
//     rd_en    - load rd_data from word addr; rd_data holds otherwise
//     addr     - word index, already range-checked by the caller
//     be       - byte-lane enables, bit k covers bits 8k+7:8k
//     wr_data  - write data
//     rd_data  - registered read data
module mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = 10
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic                rd_en,
  input  logic [IDX_W-1:0]    addr,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0]   wr_data,
  output logic [DATA_W-1:0]   rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < DATA_W / 8; k++) begin
        if (be[k]) begin
          mem[addr][8*k +: 8] <= wr_data[8*k +: 8];
        end
      end
    end
    if (rd_en) begin
      rd_data <= mem[addr];
    end
  end

endmodule

// File: rtl/param_memory.sv
// param_memory
//   Single-port word memory with a strobe/ready handshake and a configurable
//   number of wait states per access. Out-of-range accesses complete with an
//   error pulse instead of touching storage.
//   Ports:
//     clk             - clock, rising edge
//     rst             - synchronous active-high reset
//     memory_addr     - word address
//     memory_as_      - active-low address strobe (request)
//     memory_rw       - 1 = read, 0 = write
//     memory_be       - byte-lane write enables
//     memory_wr_data  - write data
//     memory_rd_data  - read data, held until the next read completes
//     memory_ready    - a request can be accepted this cycle
//     memory_rd_valid - one-cycle pulse, memory_rd_data updated
//     memory_err      - one-cycle pulse, completed access was out of range
module param_memory
  import mem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 30,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   memory_addr,
  input  logic                memory_as_,
  input  logic                memory_rw,
  input  logic [DATA_W/8-1:0] memory_be,
  input  logic [DATA_W-1:0]   memory_wr_data,
  output logic [DATA_W-1:0]   memory_rd_data,
  output logic                memory_ready,
  output logic                memory_rd_valid,
  output logic                memory_err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  // The counter starts at N-1 so that the access executes on the N-th
  // edge after acceptance, when the counter has reached zero.
  localparam logic [WAIT_CNT_W-1:0] CNT_LOAD = WAIT_CNT_W'(WAIT_STATES - 1);

  state_t state, next_state;
  logic [WAIT_CNT_W-1:0] cnt;

  logic [ADDR_W-1:0] lat_addr;
  logic              lat_rw;
  logic [BE_W-1:0]   lat_be;
  logic [DATA_W-1:0] lat_wr_data;

  logic              accept;
  logic              exec;
  logic              use_lat;
  logic [ADDR_W-1:0] ex_addr;
  logic              ex_rw;
  logic [BE_W-1:0]   ex_be;
  logic [DATA_W-1:0] ex_wr_data;
  logic              in_range;
  logic              arr_wr_en;
  logic              arr_rd_en;
  logic [DATA_W-1:0] arr_rd_data;
  logic              rd_zero;

  // Requests arriving while reset is asserted are dropped.
  assign accept = (state == IDLE) && !memory_as_ && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // With zero wait states the access executes on the accepting edge using
  // the live inputs; otherwise it executes from the latched copy when the
  // counter expires. A reset edge suppresses execution, which aborts any
  // pending access.
  always_comb begin
    next_state   = state;
    memory_ready = 1'b0;
    exec         = 1'b0;
    use_lat      = 1'b0;
    case (state)
      IDLE: begin
        memory_ready = 1'b1;
        if (accept) begin
          if (WAIT_STATES == 0) begin
            exec = 1'b1;
          end else begin
            next_state = BUSY;
          end
        end
      end
      BUSY: begin
        use_lat = 1'b1;
        if (cnt == '0) begin
          exec       = !rst;
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= CNT_LOAD;
    end else if (state == BUSY && cnt != '0) begin
      cnt <= cnt - WAIT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lat_addr    <= memory_addr;
      lat_rw      <= memory_rw;
      lat_be      <= memory_be;
      lat_wr_data <= memory_wr_data;
    end
  end

  assign ex_addr    = use_lat ? lat_addr    : memory_addr;
  assign ex_rw      = use_lat ? lat_rw      : memory_rw;
  assign ex_be      = use_lat ? lat_be      : memory_be;
  assign ex_wr_data = use_lat ? lat_wr_data : memory_wr_data;

  // Full-width compare so upper address bits can never alias into storage.
  assign in_range  = ({1'b0, ex_addr} < DEPTH_L);
  assign arr_wr_en = exec && (ex_rw == MEM_WRITE) && in_range;
  assign arr_rd_en = exec && (ex_rw == MEM_READ)  && in_range;

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .wr_en   (arr_wr_en),
    .rd_en   (arr_rd_en),
    .addr    (ex_addr[IDX_W-1:0]),
    .be      (ex_be),
    .wr_data (ex_wr_data),
    .rd_data (arr_rd_data)
  );

  // The array read register is not reset, so a flag forces the visible read
  // data to zero after reset and after an out-of-range read; a good read
  // clears it and exposes the array register, which holds until the next read.
  always_ff @(posedge clk) begin
    if (rst) begin
      memory_rd_valid <= 1'b0;
      memory_err      <= 1'b0;
      rd_zero         <= 1'b1;
    end else begin
      memory_rd_valid <= exec && (ex_rw == MEM_READ);
      memory_err      <= exec && !in_range;
      if (exec && (ex_rw == MEM_READ)) begin
        rd_zero <= !in_range;
      end
    end
  end

  assign memory_rd_data = rd_zero ? '0 : arr_rd_data;

endmodule
